// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
//   Shared constants and types for the instruction-fetch stage.
//   - Word / enable / reset literal values used by the fetch logic.
//   - fetch_state_t : fetch state machine codes (not visible outside).
//   - if_id_t       : contents of the IF/ID pipeline register.
//   - is_misaligned : word-alignment test on the two low address bits.
package inst_fetch_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic        RST_ENABLE   = 1'b1;

    typedef enum logic [1:0] {
        FETCH_IDLE       = 2'd0,
        FETCH_RUN        = 2'd1,
        FETCH_WAIT_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
    } if_id_t;

    function automatic logic is_misaligned(input logic [1:0] addr_low);
        return addr_low != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register between fetch and decode.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset (clears to a bubble)
//     load      in   capture load_data
//     bubble    in   replace contents with an empty slot (wins over load)
//     load_data in   entry to capture
//     if_id     out  registered entry presented to decode
//   Neither load nor bubble: contents hold (stall).
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t load_data,
    output if_id_t if_id
);

    if_id_t if_id_reg_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            if_id_reg_q <= '0;
        end else if (bubble) begin
            // An empty slot is all zero: ZERO_WORD instruction is a NOP to decode.
            if_id_reg_q <= '0;
        end else if (load) begin
            if_id_reg_q <= load_data;
        end
    end

    assign if_id = if_id_reg_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction fetch stage: owns the PC, the fetch state machine, branch
//   and exception redirect, misaligned-fetch detection and drives the
//   instruction ROM (which answers combinationally in the same cycle).
//   Ports:
//     clk, rst           clock / synchronous active-high reset
//     stall_i            hold PC and IF/ID
//     flush_i, new_pc_i  exception redirect (highest priority after rst)
//     branch_flag_i,
//     branch_target_i    taken branch/jump redirect from decode
//     inst_i             ROM data for instaddr_o
//     ce_o, instaddr_o   ROM chip enable and byte address
//     if_pc_o, if_inst_o,
//     if_valid_o,
//     if_adel_o          IF/ID register contents toward decode
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] inst_i,
    output logic        ce_o,
    output logic [31:0] instaddr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        if_adel_o
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         ifid_load, ifid_bubble;
    if_id_t       ifid_data, ifid_q;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_data   = '{pc: pc_reg, inst: inst_i, valid: 1'b1, adel: 1'b0};

        if (flush_i) begin
            // Exception redirect beats stall and branch in every state.
            pc_next     = new_pc_i;
            state_next  = FETCH_RUN;
            ifid_bubble = 1'b1;
        end else begin
            case (state_reg)
                FETCH_IDLE: begin
                    // PC already holds RESET_PC; it becomes the first fetch.
                    state_next = FETCH_RUN;
                end
                FETCH_RUN: begin
                    // Under stall the branch is dropped: decode re-presents it.
                    if (!stall_i) begin
                        ifid_load = 1'b1;
                        if (is_misaligned(pc_reg[1:0])) begin
                            // The ROM word at a misaligned address is meaningless,
                            // so only the faulting PC travels with the adel flag.
                            ifid_data.inst  = ZERO_WORD;
                            ifid_data.valid = 1'b0;
                            ifid_data.adel  = 1'b1;
                            state_next      = FETCH_WAIT_FLUSH;
                        end else if (branch_flag_i) begin
                            // Captured word is the delay slot; target may be
                            // misaligned and is trapped on its own fetch.
                            pc_next = branch_target_i;
                        end else begin
                            pc_next = pc_reg + PC_STEP;
                        end
                    end
                end
                FETCH_WAIT_FLUSH: begin
                    // adel entry is shown for exactly one unstalled cycle,
                    // then the slot empties until the handler redirect arrives.
                    if (!stall_i) begin
                        ifid_bubble = 1'b1;
                    end
                end
                default: begin
                    state_next = FETCH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg <= FETCH_IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .bubble    (ifid_bubble),
        .load_data (ifid_data),
        .if_id     (ifid_q)
    );

    assign ce_o       = (state_reg == FETCH_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
    assign instaddr_o = (ce_o == CHIP_ENABLE) ? pc_reg : ZERO_WORD;
    assign if_pc_o    = ifid_q.pc;
    assign if_inst_o  = ifid_q.inst;
    assign if_valid_o = ifid_q.valid;
    assign if_adel_o  = ifid_q.adel;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: RESET_PC = 0, directed then random stimulus.
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, branch = 1'b0;
    logic [31:0] new_pc = '0, target = '0;
    logic [31:0] inst;
    logic        ce;
    logic [31:0] addr, if_pc, if_inst;
    logic        if_valid, if_adel;

    // DUT 1: RESET_PC near the top of the address space, wrap check.
    logic        rst1 = 1'b1;
    logic        stall1 = 1'b0, flush1 = 1'b0, branch1 = 1'b0;
    logic [31:0] new_pc1 = '0, target1 = '0;
    logic [31:0] inst1;
    logic        ce1;
    logic [31:0] addr1, if_pc1, if_inst1;
    logic        if_valid1, if_adel1;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction ROM contents, defined for every byte address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h3401_0001;
        if (a == 32'h4) return 32'h3402_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign inst  = rom_word(addr);
    assign inst1 = rom_word(addr1);

    inst_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(new_pc),
        .branch_flag_i(branch), .branch_target_i(target), .inst_i(inst),
        .ce_o(ce), .instaddr_o(addr), .if_pc_o(if_pc), .if_inst_o(if_inst),
        .if_valid_o(if_valid), .if_adel_o(if_adel)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut1 (
        .clk(clk), .rst(rst1), .stall_i(stall1), .flush_i(flush1), .new_pc_i(new_pc1),
        .branch_flag_i(branch1), .branch_target_i(target1), .inst_i(inst1),
        .ce_o(ce1), .instaddr_o(addr1), .if_pc_o(if_pc1), .if_inst_o(if_inst1),
        .if_valid_o(if_valid1), .if_adel_o(if_adel1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model for DUT 0 ----------------
    // fetching: ROM is being read; trapped: halted after an address error.
    bit          m_fetching, m_trapped;
    logic [31:0] m_pc, m_ifpc, m_ifinst;
    bit          m_ifvalid, m_ifadel;

    task automatic model_edge();
        if (rst) begin
            m_fetching = 0; m_trapped = 0; m_pc = 32'h0;
            m_ifpc = 0; m_ifinst = 0; m_ifvalid = 0; m_ifadel = 0;
        end else if (flush) begin
            m_fetching = 1; m_trapped = 0; m_pc = new_pc;
            m_ifpc = 0; m_ifinst = 0; m_ifvalid = 0; m_ifadel = 0;
        end else if (m_trapped) begin
            if (!stall) begin
                m_ifpc = 0; m_ifinst = 0; m_ifvalid = 0; m_ifadel = 0;
            end
        end else if (!m_fetching) begin
            m_fetching = 1;               // first fetch one cycle after release
        end else if (!stall) begin
            m_ifpc = m_pc;
            if (m_pc % 4 != 0) begin
                m_ifinst = 0; m_ifvalid = 0; m_ifadel = 1;
                m_fetching = 0; m_trapped = 1;
            end else begin
                m_ifinst = rom_word(m_pc); m_ifvalid = 1; m_ifadel = 0;
                m_pc = branch ? target : m_pc + 4;
            end
        end
    endtask

    // Single compare process: update model on each edge, check on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("m_ce",    {31'b0, ce}, {31'b0, m_fetching});
            chk("m_addr",  addr, m_fetching ? m_pc : 32'h0);
            chk("m_ifpc",  if_pc, m_ifpc);
            chk("m_ifinst", if_inst, m_ifinst);
            chk("m_valid", {31'b0, if_valid}, {31'b0, m_ifvalid});
            chk("m_adel",  {31'b0, if_adel}, {31'b0, m_ifadel});
        end
    end

    // ---------------- wrap test on DUT 1 ----------------
    initial begin
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("wrap_a0", addr1, 32'hFFFF_FFF8);
        chk("wrap_ce", {31'b0, ce1}, 32'h1);
        @(negedge clk);
        chk("wrap_a1", addr1, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_a2", addr1, 32'h0000_0000);
        rst1 = 1'b1;
        @(negedge clk);
        chk("wrap_rst_ce", {31'b0, ce1}, 32'h0);
        chk("wrap_rst_addr", addr1, 32'h0);
        rst1 = 1'b0;
        @(negedge clk);
        chk("wrap_restart", addr1, 32'hFFFF_FFF8);
    end

    // ---------------- directed then random stimulus on DUT 0 ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ce", {31'b0, ce}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_ce", {31'b0, ce}, 32'h1);
        chk("first_addr", addr, 32'h0);
        @(negedge clk);
        chk("first_inst", if_inst, 32'h3401_0001);
        chk("first_ifpc", if_pc, 32'h0);
        chk("second_addr", addr, 32'h4);
        @(negedge clk);
        chk("pre_stall_addr", addr, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", addr, 32'h8);
            chk("stall_ifpc", if_pc, 32'h4);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("post_stall_ifpc", if_pc, 32'h8);
        chk("post_stall_addr", addr, 32'hC);
        @(negedge clk);
        chk("pre_br_addr", addr, 32'h10);
        branch = 1'b1; target = 32'h40;
        @(negedge clk);
        chk("delay_slot_pc", if_pc, 32'h10);
        chk("br_addr", addr, 32'h40);
        branch = 1'b0;
        @(negedge clk);
        chk("br_target_pc", if_pc, 32'h40);
        flush = 1'b1; new_pc = 32'h180; stall = 1'b1; branch = 1'b1; target = 32'h200;
        @(negedge clk);
        chk("flush_addr", addr, 32'h180);
        chk("flush_valid", {31'b0, if_valid}, 32'h0);
        chk("flush_inst", if_inst, 32'h0);
        flush = 1'b0; stall = 1'b0; branch = 1'b1; target = 32'h42;
        @(negedge clk);
        branch = 1'b0;
        chk("mis_addr", addr, 32'h42);
        @(negedge clk);
        chk("adel", {31'b0, if_adel}, 32'h1);
        chk("adel_pc", if_pc, 32'h42);
        chk("adel_valid", {31'b0, if_valid}, 32'h0);
        chk("adel_ce", {31'b0, ce}, 32'h0);
        @(negedge clk);
        chk("wait_ce", {31'b0, ce}, 32'h0);
        chk("wait_adel", {31'b0, if_adel}, 32'h0);
        flush = 1'b1; new_pc = 32'h180;
        @(negedge clk);
        flush = 1'b0;
        chk("handler_ce", {31'b0, ce}, 32'h1);
        chk("handler_addr", addr, 32'h180);
        @(negedge clk);
        chk("handler_ifpc", if_pc, 32'h180);

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(99) == 0);
            flush  = ($urandom_range(19) == 0);
            stall  = ($urandom_range(9) < 3);
            branch = ($urandom_range(99) < 15);
            target = {$urandom_range(32'hFFFF), 2'b00};
            if ($urandom_range(7) == 0) target[1:0] = 2'($urandom_range(3));
            new_pc = {$urandom_range(32'hFFFF), 2'b00};
            @(negedge clk);
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0; branch = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Initiator side of the instruction-ROM interface; it drives chip enable and the byte address into the instruction ROM.
- The ROM answers combinationally in the same cycle with the 32-bit word at instaddr_o[InstMemNumLog2+1:2].
- The block owns the PC, the fetch state machine, branch/exception redirect, misaligned-fetch detection and the IF/ID pipeline register feeding decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and first address fetched.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1'b1).
- stall_i  in  1  hold PC and IF/ID register (from pipeline control).
- flush_i  in  1  exception flush; redirect to new_pc_i.
- new_pc_i  in  32  exception handler address.
- branch_flag_i  in  1  taken branch/jump from decode.
- branch_target_i  in  32  branch/jump target.
- inst_i  in  32  instruction word returned by ROM (same cycle as instaddr_o).
- ce_o  out  1  ROM chip enable (ChipEnable/ChipDisable).
- instaddr_o  out  32  ROM byte address (= current PC).
- if_pc_o  out  32  PC of instruction held in IF/ID.
- if_inst_o  out  32  instruction held in IF/ID.
- if_valid_o  out  1  IF/ID holds a real instruction.
- if_adel_o  out  1  IF/ID slot carries fetch address-error exception.

Behaviour:
- State machine with states IDLE, RUN and WAIT_FLUSH; it is one-hot or encoded, but the encoding is not visible externally.
- Reset (rst high at edge):
  - state<=IDLE, pc<=RESET_PC.
  - if_pc_o, if_inst_o <= ZeroWord; if_valid_o, if_adel_o <= 0.
- Outputs are combinational from state and PC:
  - ce_o=1 only in RUN.
  - instaddr_o = pc when ce_o=1, else ZeroWord.
- IDLE: next edge with rst low -> RUN. pc is unchanged, so the first fetch is RESET_PC, one cycle after reset release.
- RUN, per edge, with priority flush > stall > misaligned > branch > sequential:
  - flush_i: pc<=new_pc_i; IF/ID <= bubble (ZeroWord, valid 0, adel 0); state stays RUN.
  - stall_i (no flush): pc and IF/ID hold. branch_flag_i is ignored, because decode is stalled too and re-presents the branch.
  - pc[1:0]!=0: IF/ID <= {pc, ZeroWord, valid 0, adel 1}; state<=WAIT_FLUSH. inst_i is not captured.
  - branch_flag_i: IF/ID <= {pc, inst_i, valid 1}; pc<=branch_target_i.
    - The word captured here is the delay-slot instruction, since decode holds the branch at pc-4.
    - A misaligned target is accepted into pc and flagged on its own fetch cycle.
  - otherwise: IF/ID <= {pc, inst_i, valid 1, adel 0}; pc<=pc+PC_STEP, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- WAIT_FLUSH:
  - ce_o=0; pc holds.
  - IF/ID holds the adel entry while stall_i=1; otherwise IF/ID <= bubble after one cycle, so adel is presented exactly one unstalled cycle.
  - flush_i -> pc<=new_pc_i, state<=RUN. Nothing else leaves WAIT_FLUSH except rst.
- Simultaneous events:
  - flush_i wins over stall_i and branch_flag_i in every state.
  - rst wins over everything, mid-stall or mid-WAIT_FLUSH included.
- if_valid_o=0 entries must be ZeroWord in if_inst_o, which is a NOP to decode.

Decomposition:
- Defines.v gains InstAddrBus, InstBus, ZeroWord, ChipEnable, ChipDisable and RstEnable, reused as-is.
- New constants in Defines.v: FetchIdle, FetchRun, FetchWaitFlush state codes.
- One natural sub-module: if_id_reg, holding the IF/ID register with load/hold/bubble controls.
- The PC, state machine and ROM drive remain in inst_fetch.

Test Plan:
- Reset then release, ROM holding 0x34010001, 0x34020002 at 0x0 and 0x4:
  - cycle 1: ce_o=0, instaddr_o=0.
  - cycle 2: ce_o=1, instaddr_o=0x0.
  - cycle 3: if_inst_o=0x34010001, if_pc_o=0x0, instaddr_o=0x4.
- stall_i high for 3 cycles at pc=0x8: instaddr_o and IF/ID are frozen for 3 cycles, then resume at 0xC with no skipped or duplicated word.
- branch_flag_i=1, target=0x40 while pc=0x10:
  - next edge: if_pc_o=0x10 (delay slot), instaddr_o=0x40.
  - following edge: if_pc_o=0x40.
- flush_i=1, new_pc_i=0x180 concurrent with stall_i=1 and branch_flag_i=1: pc=0x180, if_valid_o=0, if_inst_o=0.
- Branch to 0x42:
  - fetch at 0x42 gives if_adel_o=1, if_pc_o=0x42, if_valid_o=0, then ce_o=0 until flush_i.
  - flush_i with new_pc_i=0x180 gives a RUN fetch of 0x180.
- RESET_PC=32'hFFFF_FFF8, sequential run: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst asserted mid-run returns ce_o=0 and pc to RESET_PC on the next edge.
